// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between requesters A and B. Ties go round-robin, or to A when RAM_ARB_FIXED_PRI_EN is defined.
// Grant is one cycle after a sampled req, read data one cycle after grant, at most one access per two cycles; held requests wait.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_a_in,
  input  logic                  we_a_in,
  input  logic [ADDR_WIDTH-1:0] addr_a_in,
  input  logic [DATA_WIDTH-1:0] wdata_a_in,
  output logic                  gnt_a_out,
  output logic [DATA_WIDTH-1:0] rdata_a_out,
  output logic                  rvalid_a_out,
  input  logic                  req_b_in,
  input  logic                  we_b_in,
  input  logic [ADDR_WIDTH-1:0] addr_b_in,
  input  logic [DATA_WIDTH-1:0] wdata_b_in,
  output logic                  gnt_b_out,
  output logic [DATA_WIDTH-1:0] rdata_b_out,
  output logic                  rvalid_b_out,
  output logic                  ram_we_out,
  output logic                  ram_enable_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  busy_out
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_last_owner;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_gnt_a;
  logic                  r_gnt_b;
  logic                  r_rvalid_a;
  logic                  r_rvalid_b;
  logic [DATA_WIDTH-1:0] r_rdata_a;
  logic [DATA_WIDTH-1:0] r_rdata_b;
  logic                  r_ram_we;
  logic                  r_ram_en;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_busy;

  logic                  w_any_req;
  logic                  w_pick_b;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  assign w_any_req = req_a_in | req_b_in;

`ifdef RAM_ARB_FIXED_PRI_EN
  assign w_pick_b = req_b_in & ~req_a_in;
`else
  // On a tie B wins only if A was served last.
  assign w_pick_b = req_b_in & (~req_a_in | (r_last_owner == OWN_A));
`endif

  assign w_sel_we    = w_pick_b ? we_b_in    : we_a_in;
  assign w_sel_addr  = w_pick_b ? addr_b_in  : addr_a_in;
  assign w_sel_wdata = w_pick_b ? wdata_b_in : wdata_a_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_A;
      r_last_owner <= OWN_B;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_gnt_a      <= 1'b0;
      r_gnt_b      <= 1'b0;
      r_rvalid_a   <= 1'b0;
      r_rvalid_b   <= 1'b0;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
      r_ram_we     <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_addr   <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rvalid_a <= 1'b0;
          r_rvalid_b <= 1'b0;
          if (w_any_req) begin
            r_state    <= S_ACCESS;
            r_owner    <= w_pick_b;
            r_we       <= w_sel_we;
            r_wdata    <= w_sel_wdata;
            r_gnt_a    <= ~w_pick_b;
            r_gnt_b    <= w_pick_b;
            r_ram_addr <= w_sel_addr;
            r_ram_we   <= w_sel_we;
            r_ram_en   <= ~w_sel_we;
            r_busy     <= 1'b1;
          end
        end
        S_ACCESS: begin
          r_state      <= S_IDLE;
          r_last_owner <= r_owner;
          r_gnt_a      <= 1'b0;
          r_gnt_b      <= 1'b0;
          r_ram_we     <= 1'b0;
          r_ram_en     <= 1'b0;
          r_busy       <= 1'b0;
          // The RAM drives the bus during a read ACCESS; capture it on the closing edge.
          if (!r_we) begin
            if (r_owner == OWN_B) begin
              r_rdata_b  <= ram_data;
              r_rvalid_b <= 1'b1;
            end else begin
              r_rdata_a  <= ram_data;
              r_rvalid_a <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_data = (r_state == S_ACCESS && r_we) ? r_wdata : {DATA_WIDTH{1'bz}};

  assign gnt_a_out      = r_gnt_a;
  assign gnt_b_out      = r_gnt_b;
  assign rvalid_a_out   = r_rvalid_a;
  assign rvalid_b_out   = r_rvalid_b;
  assign rdata_a_out    = r_rdata_a;
  assign rdata_b_out    = r_rdata_b;
  assign ram_we_out     = r_ram_we;
  assign ram_enable_out = r_ram_en;
  assign ram_addr_out   = r_ram_addr;
  assign busy_out       = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM model, a transaction-level arbitration/memory reference model and a scoreboard monitor.
module tb_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          req_a_in, we_a_in, req_b_in, we_b_in;
  logic [AW-1:0] addr_a_in, addr_b_in;
  logic [DW-1:0] wdata_a_in, wdata_b_in;
  logic          gnt_a_out, rvalid_a_out, gnt_b_out, rvalid_b_out;
  logic [DW-1:0] rdata_a_out, rdata_b_out;
  logic          ram_we_out, ram_enable_out, busy_out;
  logic [AW-1:0] ram_addr_out;
  wire  [DW-1:0] ram_data;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req_a_in(req_a_in), .we_a_in(we_a_in), .addr_a_in(addr_a_in), .wdata_a_in(wdata_a_in),
    .gnt_a_out(gnt_a_out), .rdata_a_out(rdata_a_out), .rvalid_a_out(rvalid_a_out),
    .req_b_in(req_b_in), .we_b_in(we_b_in), .addr_b_in(addr_b_in), .wdata_b_in(wdata_b_in),
    .gnt_b_out(gnt_b_out), .rdata_b_out(rdata_b_out), .rvalid_b_out(rvalid_b_out),
    .ram_we_out(ram_we_out), .ram_enable_out(ram_enable_out), .ram_addr_out(ram_addr_out),
    .ram_data(ram_data), .busy_out(busy_out)
  );

  // Single-port RAM: asynchronous read while enabled, write on the rising edge.
  logic [DW-1:0] ram_mem [16];
  assign ram_data = (ram_enable_out && !ram_we_out) ? ram_mem[ram_addr_out] : {DW{1'bz}};
  always @(posedge clock) if (ram_we_out) ram_mem[ram_addr_out] <= ram_data;

  typedef struct packed {
    logic          owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  acc_t          exp_gnt_q[$];
  logic [DW-1:0] exp_ra_q[$];
  logic [DW-1:0] exp_rb_q[$];
  logic          grant_log[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            rvalid_a_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Reference model: one access at a time, each access occupies one edge-to-edge slot after its grant.
  logic [DW-1:0] mdl_mem [16];
  logic          m_busy = 1'b0;
  logic          m_last = 1'b1;
  logic          m_b_wins;
  acc_t          m_cur;

  initial forever begin
    @(posedge clock);
    if (reset) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (m_busy) begin
      m_busy = 1'b0;
      m_last = m_cur.owner;
      if (!m_cur.we) begin
        if (m_cur.owner) exp_rb_q.push_back(mdl_mem[m_cur.addr]);
        else             exp_ra_q.push_back(mdl_mem[m_cur.addr]);
      end
    end else if (req_a_in || req_b_in) begin
`ifdef RAM_ARB_FIXED_PRI_EN
      m_b_wins = !req_a_in;
`else
      if (req_a_in && req_b_in) m_b_wins = (m_last == 1'b0);
      else                      m_b_wins = req_b_in;
`endif
      if (m_b_wins) m_cur = '{owner: 1'b1, we: we_b_in, addr: addr_b_in, wdata: wdata_b_in};
      else          m_cur = '{owner: 1'b0, we: we_a_in, addr: addr_a_in, wdata: wdata_a_in};
      if (m_cur.we) mdl_mem[m_cur.addr] = m_cur.wdata;
      exp_gnt_q.push_back(m_cur);
      m_busy = 1'b1;
    end
  end

  // Monitor: bus invariants every cycle, grants and read data popped from the scoreboard.
  acc_t mon_e;
  initial forever begin
    @(negedge clock);
    check("we_en_exclusive", 32'(ram_we_out && ram_enable_out), 32'd0);
    if (!ram_we_out && !ram_enable_out) check("bus_released", 32'(ram_data === {DW{1'bz}}), 32'd1);
    if (gnt_a_out || gnt_b_out) begin
      check("gnt_both", 32'(gnt_a_out && gnt_b_out), 32'd0);
      if (exp_gnt_q.size() == 0) fail_now("gnt_unexpected");
      else begin
        mon_e = exp_gnt_q.pop_front();
        check("gnt_owner", 32'(gnt_b_out), 32'(mon_e.owner));
        check("ram_we", 32'(ram_we_out), 32'(mon_e.we));
        check("ram_en", 32'(ram_enable_out), 32'(!mon_e.we));
        check("ram_addr", 32'(ram_addr_out), 32'(mon_e.addr));
        check("busy_access", 32'(busy_out), 32'd1);
        if (mon_e.we) check("bus_wdata", 32'(ram_data), 32'(mon_e.wdata));
        grant_log.push_back(gnt_b_out);
      end
    end else begin
      check("busy_idle", 32'(busy_out), 32'd0);
    end
    if (rvalid_a_out) begin
      rvalid_a_cnt++;
      if (exp_ra_q.size() == 0) fail_now("rvalid_a_unexpected");
      else check("rdata_a", 32'(rdata_a_out), 32'(exp_ra_q.pop_front()));
    end
    if (rvalid_b_out) begin
      if (exp_rb_q.size() == 0) fail_now("rvalid_b_unexpected");
      else check("rdata_b", 32'(rdata_b_out), 32'(exp_rb_q.pop_front()));
    end
  end

  // Present one request and hold it until the grant is seen, then drop it.
  task automatic do_req(input logic side, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    if (side) begin we_b_in = we; addr_b_in = addr; wdata_b_in = d; req_b_in = 1'b1; end
    else      begin we_a_in = we; addr_a_in = addr; wdata_a_in = d; req_a_in = 1'b1; end
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clock); #1;
      if (side ? gnt_b_out : gnt_a_out) got = 1'b1;
    end
    if (side) req_b_in = 1'b0; else req_a_in = 1'b0;
    if (!got) fail_now(side ? "grant_timeout_b" : "grant_timeout_a");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  time t_a, t_b;
  logic exp_owner;

  initial begin
    reset = 1'b1;
    req_a_in = 0; we_a_in = 0; addr_a_in = '0; wdata_a_in = '0;
    req_b_in = 0; we_b_in = 0; addr_b_in = '0; wdata_b_in = '0;
    for (int i = 0; i < 16; i++) begin ram_mem[i] = '0; mdl_mem[i] = '0; end
    repeat (2) @(posedge clock);
    #1;
    check("rst_gnt_a", 32'(gnt_a_out), 32'd0);
    check("rst_gnt_b", 32'(gnt_b_out), 32'd0);
    check("rst_rvalid", 32'(rvalid_a_out | rvalid_b_out), 32'd0);
    check("rst_strobes", 32'(ram_we_out | ram_enable_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_addr", 32'(ram_addr_out), 32'd0);
    check("rst_rdata_a", 32'(rdata_a_out), 32'd0);
    check("rst_rdata_b", 32'(rdata_b_out), 32'd0);
    check("rst_bus_z", 32'(ram_data === {DW{1'bz}}), 32'd1);
    reset = 1'b0;

    // A-only write then read
    do_req(1'b0, 1'b1, 4'h3, 8'hA5);
    check("wr_we_strobe", 32'(ram_we_out), 32'd1);
    check("wr_bus", 32'(ram_data), 32'hA5);
    do_req(1'b0, 1'b0, 4'h3, 8'h00);
    @(posedge clock); #1;
    check("rd_rvalid_a", 32'(rvalid_a_out), 32'd1);
    check("rd_rdata_a", 32'(rdata_a_out), 32'hA5);

    // Simultaneous requests after reset: A first, B two cycles later
    do_reset();
    fork
      begin do_req(1'b0, 1'b1, 4'h1, 8'h11); t_a = $time; end
      begin do_req(1'b1, 1'b1, 4'h2, 8'h22); t_b = $time; end
    join
    check("tie_b_after_a", 32'(t_b - t_a), 32'd20);
    do_req(1'b0, 1'b0, 4'h1, 8'h00);
    do_req(1'b0, 1'b0, 4'h2, 8'h00);

    // Continuous contention for 8 accesses
    do_reset();
    @(negedge clock);
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, AW'(8 + i), DW'(8'hA0 + i));
      for (int i = 0; i < 4; i++) do_req(1'b1, 1'b1, AW'(12 + i), DW'(8'hB0 + i));
    join
    @(negedge clock); #1;
    check("contention_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef RAM_ARB_FIXED_PRI_EN
      exp_owner = (i >= 4);
`else
      exp_owner = i[0];
`endif
      check($sformatf("contention_order_%0d", i), 32'(grant_log[i]), 32'(exp_owner));
    end

    // Full sweep: B writes addr=data, A reads back descending
    for (int a = 0; a < 16; a++) do_req(1'b1, 1'b1, AW'(a), DW'(a));
    @(negedge clock);
    rvalid_a_cnt = 0;
    for (int a = 15; a >= 0; a--) do_req(1'b0, 1'b0, AW'(a), 8'h00);
    repeat (2) @(posedge clock);
    #1;
    check("sweep_rvalid_count", 32'(rvalid_a_cnt), 32'd16);

    // Randomized concurrent traffic
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1 do_req(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1 do_req(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
      end
    join
    repeat (3) @(posedge clock);
    #1;

    // Reset during the ACCESS of an A read
    do_req(1'b0, 1'b0, 4'h5, 8'h00);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_gnt_a", 32'(gnt_a_out), 32'd0);
    check("mid_strobes", 32'(ram_we_out | ram_enable_out), 32'd0);
    check("mid_busy", 32'(busy_out), 32'd0);
    check("mid_bus_z", 32'(ram_data === {DW{1'bz}}), 32'd1);
    check("mid_rvalid_a", 32'(rvalid_a_out), 32'd0);
    check("mid_rdata_a", 32'(rdata_a_out), 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("mid_no_late_rvalid", 32'(rvalid_a_out), 32'd0);

    check("left_grants", 32'(exp_gnt_q.size()), 32'd0);
    check("left_reads_a", 32'(exp_ra_q.size()), 32'd0);
    check("left_reads_b", 32'(exp_rb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
